// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - keypad types, encoder FSM states and the one-hot to key decode
package calc_pkg;

    typedef struct packed {
        logic clear;
        logic equals;
        logic op_div;
        logic op_mul;
        logic op_sub;
        logic op_add;
        logic num_9;
        logic num_8;
        logic num_7;
        logic num_6;
        logic num_5;
        logic num_4;
        logic num_3;
        logic num_2;
        logic num_1;
        logic num_0;
    } buttons_t;

    // Enum value equals the bit position of the matching field in buttons_t.
    typedef enum logic [3:0] {
        B_NUM_0, B_NUM_1, B_NUM_2, B_NUM_3, B_NUM_4,
        B_NUM_5, B_NUM_6, B_NUM_7, B_NUM_8, B_NUM_9,
        B_OP_ADD, B_OP_SUB, B_OP_MUL, B_OP_DIV, B_EQUALS, B_CLEAR
    } active_button_t;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        WAIT_RELEASE
    } button_enc_state_e;

    // Meaningful only for a single set bit; an empty vector decodes to B_CLEAR.
    function automatic active_button_t buttons2button(input buttons_t buttons);
        logic [$bits(buttons_t)-1:0] vec;
        active_button_t result;
        vec = buttons;
        result = B_CLEAR;
        for (int i = 0; i < $bits(buttons_t); i++) begin
            if (vec[i]) result = active_button_t'(4'(i));
        end
        return result;
    endfunction

endpackage

// File: rtl/button_encoder_sync.sv
// rtl/button_encoder_sync.sv - two-flop synchronizer, synchronous reset to zero
module button_sync #(
    parameter int Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_encoder.sv
// rtl/button_encoder.sv - debounced keypad to single key-event encoder with one-entry output buffer
module button_encoder
    import calc_pkg::*;
#(
    parameter int unsigned DebounceCycles = 1000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  buttons_t       buttons_i,
    output active_button_t button_o,
    output logic           valid_o,
    input  logic           ready_i,
    output logic           overrun_o
);

    localparam int CntW = $clog2(DebounceCycles + 1);
    localparam logic [CntW:0] Limit = DebounceCycles[CntW:0];

    if (DebounceCycles == 0) begin : g_bad_param
        $fatal(1, "button_encoder: DebounceCycles must be at least 1");
    end

    logic [$bits(buttons_t)-1:0] sync_vec;
    button_enc_state_e           state, state_next;
    logic [CntW-1:0]             count, count_next;
    logic [CntW:0]               count_inc;
    active_button_t              key, key_next, sync_key;
    logic                        is_none, is_single, emit;

    button_sync #(.Width($bits(buttons_t))) u_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (buttons_i),
        .q   (sync_vec)
    );

    assign is_none   = (sync_vec == '0);
    assign is_single = $onehot(sync_vec);
    assign sync_key  = buttons2button(sync_vec);
    // One bit wider than the counter so the limit compare never wraps.
    assign count_inc = {1'b0, count} + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            count <= '0;
            key   <= B_CLEAR;
        end else begin
            state <= state_next;
            count <= count_next;
            key   <= key_next;
        end
    end

    // IDLE always holds count at zero, so count_inc there is the first stable sample.
    always_comb begin
        state_next = state;
        count_next = count;
        key_next   = key;
        emit       = 1'b0;
        unique case (state)
            IDLE, DEBOUNCE: begin
                if (is_single && (state == IDLE || sync_key == key)) begin
                    key_next = sync_key;
                    if (count_inc >= Limit) begin
                        emit       = 1'b1;
                        state_next = WAIT_RELEASE;
                        count_next = '0;
                    end else begin
                        state_next = DEBOUNCE;
                        count_next = count_inc[CntW-1:0];
                    end
                end else begin
                    state_next = IDLE;
                    count_next = '0;
                end
            end
            WAIT_RELEASE: begin
                if (!is_none) begin
                    count_next = '0;
                end else if (count_inc >= Limit) begin
                    state_next = IDLE;
                    count_next = '0;
                end else begin
                    count_next = count_inc[CntW-1:0];
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o   <= 1'b0;
            button_o  <= B_CLEAR;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (valid_o && ready_i) valid_o <= 1'b0;
            if (emit) begin
                if (!valid_o || ready_i) begin
                    valid_o  <= 1'b1;
                    button_o <= sync_key;
                end else begin
                    overrun_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_encoder.sv
// tb/tb_button_encoder.sv - directed and randomized keypad sequences against a streak-based reference model
module tb_button_encoder;
    import calc_pkg::*;

    localparam int Dc = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [15:0]    btn = '0;
    logic           ready = 1'b0;
    active_button_t button;
    logic           valid;
    logic           overrun;

    button_encoder #(.DebounceCycles(Dc)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .buttons_i (btn),
        .button_o  (button),
        .valid_o   (valid),
        .ready_i   (ready),
        .overrun_o (overrun)
    );

    always #5 clk = ~clk;

    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    logic           mv;
    active_button_t mb;
    logic           mo;
    bit             armed;
    logic [15:0]    last_v;
    int             run;
    logic [4:0]     evq[$];

    task automatic check_outputs(input string tag);
        checks++;
        assert (valid === mv) else begin
            errors++;
            $error("FAIL %s valid_o cycle %0d: got %b expected %b", tag, cyc, valid, mv);
        end
        checks++;
        assert (button === mb) else begin
            errors++;
            $error("FAIL %s button_o cycle %0d: got %0d expected %0d", tag, cyc, button, mb);
        end
        checks++;
        assert (overrun === mo) else begin
            errors++;
            $error("FAIL %s overrun_o cycle %0d: got %b expected %b", tag, cyc, overrun, mo);
        end
    endtask

    // An event sampled now is visible three clock edges later (two sync flops, one FSM edge).
    task automatic step(input logic [15:0] v, input logic r, input logic ev, input active_button_t k,
                        input string tag);
        logic [4:0] e;
        logic       hs;
        btn   = v;
        ready = r;
        evq.push_back({ev, k});
        @(posedge clk);
        #1;
        cyc++;
        e  = evq.pop_front();
        hs = mv && r;
        mo = 1'b0;
        if (e[4]) begin
            if (!mv || hs) begin
                mv = 1'b1;
                mb = active_button_t'(e[3:0]);
            end else begin
                mo = 1'b1;
            end
        end else if (hs) begin
            mv = 1'b0;
        end
        check_outputs(tag);
    endtask

    // rmode: 0 ready low, 1 ready high, 2 random ready each cycle.
    task automatic seg(input logic [15:0] v, input int len, input int rmode, input string tag);
        for (int j = 0; j < len; j++) begin
            logic           r;
            logic           ev;
            active_button_t k;
            if (v != last_v) run = 0;
            else run++;
            last_v = v;
            ev = 1'b0;
            k  = B_CLEAR;
            if (run == Dc - 1) begin
                if (armed && $onehot(v)) begin
                    ev    = 1'b1;
                    k     = active_button_t'(4'($clog2(v)));
                    armed = 1'b0;
                end else if (!armed && v == '0) begin
                    armed = 1'b1;
                end
            end
            r = (rmode == 2) ? 1'($urandom_range(0, 1)) : rmode[0];
            step(v, r, ev, k, tag);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        btn   = '0;
        ready = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        evq    = '{5'd0, 5'd0};
        mv     = 1'b0;
        mb     = B_CLEAR;
        mo     = 1'b0;
        armed  = 1'b1;
        last_v = '1;
        run    = 0;
        check_outputs("reset");
        rst = 1'b0;
    endtask

    localparam logic [15:0] K1 = 16'h0002, K3 = 16'h0008, K5 = 16'h0020, K7 = 16'h0080;
    localparam logic [15:0] K8 = 16'h0100, K9 = 16'h0200, KADD = 16'h0400;

    initial begin
        do_reset();
        do_reset();

        seg(K5, 20, 1, "t1_press");
        seg('0, 6, 1, "t1_release");

        for (int i = 0; i < 5; i++) begin
            seg(K5, 2, 1, "t2_bounce");
            seg('0, 2, 1, "t2_bounce");
        end
        seg(K5, 8, 1, "t2_steady");
        seg('0, 6, 1, "t2_release");

        seg(K1 | KADD, 10, 1, "t3_chord");
        seg('0, 6, 1, "t3_release");
        seg(KADD, 8, 1, "t3_add");
        seg('0, 6, 1, "t3_release");

        seg(K7, 6, 0, "t4_num7");
        seg('0, 6, 0, "t4_release");
        seg(K8, 6, 0, "t4_num8");
        seg('0, 4, 0, "t4_stall");
        seg('0, 6, 1, "t4_drain");

        seg(K3, 50, 2, "t5_hold");
        seg('0, 3, 1, "t5_short_rel");
        seg(K3, 5, 1, "t5_blocked");
        seg('0, 4, 1, "t5_release");
        seg(K3, 6, 1, "t5_repress");
        seg('0, 6, 1, "t5_release");

        seg(K3, 3, 1, "t6_debounce");
        seg('0, 2, 1, "t6_debounce");
        do_reset();
        seg('0, 8, 1, "t6_after_rst");
        seg(K9, 6, 0, "t6_pending");
        seg('0, 2, 0, "t6_pending");
        do_reset();
        seg('0, 8, 1, "t6_after_rst");

        for (int i = 0; i < 80; i++) begin
            logic [15:0] v;
            int          a;
            int          b;
            seg('0, $urandom_range(1, 7), $urandom_range(0, 2), "rand_gap");
            a = $urandom_range(0, 15);
            if ($urandom_range(0, 3) != 0) begin
                v = 16'h1 << a;
            end else begin
                b = (a + $urandom_range(1, 15)) % 16;
                v = (16'h1 << a) | (16'h1 << b);
            end
            seg(v, $urandom_range(1, 8), $urandom_range(0, 2), "rand_key");
        end
        seg('0, 8, 1, "final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
